// File: rtl/qbank_write_scheduler.sv
// Queues Q-bank update requests and replays each as a SETUP/WRITE/HOLD write to one action bank.
// Define QSCHED_BROADCAST_EN to add req_bcast, which writes the entry into all 16 banks at once.
module qbank_write_scheduler #(
  parameter int STATE_W    = 6,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_action,
  input  logic [STATE_W-1:0] req_state,
  input  logic [DATA_W-1:0]  req_data,
`ifdef QSCHED_BROADCAST_EN
  input  logic               req_bcast,
`endif
  output logic [15:0]        bank_en,
  output logic [STATE_W-1:0] bank_addr,
  output logic [DATA_W-1:0]  bank_wdata,
  output logic               busy,
  output logic               done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [3:0]         act_mem   [FIFO_DEPTH];
  logic [STATE_W-1:0] state_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  data_mem  [FIFO_DEPTH];
`ifdef QSCHED_BROADCAST_EN
  logic               bcast_mem [FIFO_DEPTH];
  logic               work_bcast;
`endif

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] occ_next;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] work_action;

  assign fifo_empty = (occupancy == '0);
  // req_ready is already !full, so a full FIFO never pushes even when popping.
  assign push = req_valid && req_ready;
  assign pop  = !fifo_empty && ((state == S_IDLE) || (state == S_HOLD));

  always_comb begin
    occ_next = occupancy;
    if (push && !pop) begin
      occ_next = occupancy + CNT_W'(1);
    end else if (!push && pop) begin
      occ_next = occupancy - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      act_mem[wr_ptr]   <= req_action;
      state_mem[wr_ptr] <= req_state;
      data_mem[wr_ptr]  <= req_data;
`ifdef QSCHED_BROADCAST_EN
      bcast_mem[wr_ptr] <= req_bcast;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      req_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occupancy <= occ_next;
      req_ready <= (occ_next != FULL_CNT);
    end
  end

  // Working registers double as the bank address/data outputs, so they only move on a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      work_action <= '0;
      bank_addr   <= '0;
      bank_wdata  <= '0;
`ifdef QSCHED_BROADCAST_EN
      work_bcast  <= 1'b0;
`endif
    end else begin
      if (pop) begin
        work_action <= act_mem[rd_ptr];
        bank_addr   <= state_mem[rd_ptr];
        bank_wdata  <= data_mem[rd_ptr];
`ifdef QSCHED_BROADCAST_EN
        work_bcast  <= bcast_mem[rd_ptr];
`endif
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          state <= S_WRITE;
          cnt   <= WR_LOAD;
        end
        S_WRITE: begin
          if (cnt == '0) begin
            state <= S_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD: begin
          state <= pop ? S_SETUP : S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bank_en = '0;
    if (state == S_WRITE) begin
`ifdef QSCHED_BROADCAST_EN
      bank_en = work_bcast ? 16'hFFFF : (16'd1 << work_action);
`else
      bank_en = 16'd1 << work_action;
`endif
    end
  end

  assign done = (state == S_HOLD);
  assign busy = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_qbank_write_scheduler.sv
// Scoreboard bench for qbank_write_scheduler: stimulus queues expected writes, a monitor checks them.
module tb_qbank_write_scheduler;

  localparam int WR    = 4;
  localparam int SW    = 6;
  localparam int DW    = 16;
  localparam int CLK_P = 10;

  typedef struct {
    logic [15:0]   en;
    logic [SW-1:0] state;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_action;
  logic [SW-1:0] req_state;
  logic [DW-1:0] req_data;
`ifdef QSCHED_BROADCAST_EN
  logic          req_bcast;
`endif
  logic [15:0]   bank_en;
  logic [SW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic          busy;
  logic          done;

  exp_t sb[$];
  longint rise_t[$];
  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  qbank_write_scheduler #(
    .STATE_W(SW), .DATA_W(DW), .FIFO_DEPTH(4), .WR_CYCLES(WR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_action(req_action),
    .req_state(req_state),
    .req_data(req_data),
`ifdef QSCHED_BROADCAST_EN
    .req_bcast(req_bcast),
`endif
    .bank_en(bank_en),
    .bank_addr(bank_addr),
    .bank_wdata(bank_wdata),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Drives one request from a falling edge and records its acceptance edge index.
  task automatic send(input logic [3:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d,
                      input bit bc, input bit keep, output longint acc);
    int budget;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_action = a;
    req_state  = s;
    req_data   = d;
`ifdef QSCHED_BROADCAST_EN
    req_bcast  = bc;
`endif
    budget = 0;
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    acc     = $time / CLK_P;
    e.en    = bc ? 16'hFFFF : (16'd1 << a);
    e.state = s;
    e.data  = d;
    sb.push_back(e);
    if (!keep) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = 0;
    while (done_seen < target && budget < 500) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check("done_count", done_seen, target);
  endtask

  task automatic check_single();
    longint n;
    send(4'd5, 6'd3, 16'h00A5, 1'b0, 1'b0, n);
    @(posedge clk); #1;
    check("setup_en", bank_en, 16'h0000);
    check("setup_addr", bank_addr, 6'd3);
    check("setup_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("first_en", bank_en, 16'h0020);
    check("first_addr", bank_addr, 6'd3);
    check("first_wdata", bank_wdata, 16'h00A5);
    repeat (WR - 1) @(posedge clk);
    @(posedge clk); #1;
    check("first_done", done, 1'b1);
    check("first_en_off", bank_en, 16'h0000);
    @(posedge clk); #1;
    check("first_done_off", done, 1'b0);
    check("first_busy_off", busy, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every rising bank_en and checks length and done pulse.
  initial begin
    logic [15:0] prev_en;
    int run;
    exp_t e;
    prev_en = '0;
    run = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        if (prev_en != 0) check("abort_no_done", done, 1'b0);
        prev_en = '0;
        run = 0;
      end else begin
        if (bank_en != 0 && prev_en == 0) begin
          rise_t.push_back($time / CLK_P);
          if (sb.size() == 0) begin
            check("unexpected_write", bank_en, 16'h0000);
          end else begin
            e = sb.pop_front();
            check("bank_en", bank_en, e.en);
            check("bank_addr", bank_addr, e.state);
            check("bank_wdata", bank_wdata, e.data);
          end
          run = 1;
        end else if (bank_en != 0) begin
          run++;
          check("en_stable", bank_en, prev_en);
        end
        if (bank_en == 0 && prev_en != 0) begin
          check("en_len", run, WR);
          check("done_after_write", done, 1'b1);
        end else if (done) begin
          check("stray_done", done, 1'b0);
        end
        if (done) done_seen++;
        prev_en = bank_en;
      end
    end
  end

  initial begin
    #(CLK_P * 20000);
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint acc[6];
    longint ta;
    longint td;
    int base;
    int rb;
    rst = 1'b1;
    req_valid = 1'b0;
    req_action = '0;
    req_state = '0;
    req_data = '0;
`ifdef QSCHED_BROADCAST_EN
    req_bcast = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_bank_en", bank_en, 16'h0000);
    check("rst_addr", bank_addr, 6'd0);
    check("rst_wdata", bank_wdata, 16'h0000);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 1'b1);

    check_single();

    $display("[TB] sweep of all actions");
    base = done_seen;
    rb = rise_t.size();
    for (int a = 0; a < 16; a++) begin
      send(4'(a), 6'(a + 8), 16'h1000 + 16'(a), 1'b0, a != 15, ta);
    end
    wait_done(base + 16);
    @(posedge clk); #1;
    check("sweep_busy_off", busy, 1'b0);
    if (rise_t.size() >= rb + 16) begin
      for (int i = 1; i < 16; i++) begin
        check("sweep_spacing", 32'(rise_t[rb + i] - rise_t[rb + i - 1]), WR + 2);
      end
    end else begin
      check("sweep_rises", rise_t.size() - rb, 16);
    end

    $display("[TB] fill the queue");
    base = done_seen;
    for (int i = 0; i < 5; i++) begin
      send(4'(10 + i), 6'(40 + i), 16'hBEE0 + 16'(i), 1'b0, 1'b1, acc[i]);
    end
    #1;
    check("full_ready", req_ready, 1'b0);
    send(4'd15, 6'd45, 16'hBEE5, 1'b0, 1'b0, acc[5]);
    check("fill_burst", 32'(acc[4] - acc[0]), 32'd4);
    check("fill_holdoff", 32'(acc[5] - acc[0]), WR + 4);
    wait_done(base + 6);
    @(posedge clk); #1;

    $display("[TB] push and pop together");
    base = done_seen;
    send(4'd1, 6'd11, 16'h0A0A, 1'b0, 1'b1, ta);
    send(4'd2, 6'd22, 16'h0B0B, 1'b0, 1'b1, td);
    send(4'd3, 6'd33, 16'h0C0C, 1'b0, 1'b0, td);
    repeat (3) @(negedge clk);
    send(4'd4, 6'd44, 16'h0D0D, 1'b0, 1'b1, td);
    #1;
    check("pushpop_edge", 32'(td - ta), WR + 3);
    check("pushpop_occupancy", dut.occupancy, 3'd2);
    check("pushpop_oldest_addr", bank_addr, 6'd22);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done(base + 4);
    @(posedge clk); #1;

    $display("[TB] reset during write");
    send(4'd7, 6'd17, 16'h7777, 1'b0, 1'b1, ta);
    send(4'd9, 6'd19, 16'h9999, 1'b0, 1'b0, ta);
    @(posedge clk); #1;
    check("pre_reset_en", bank_en, 16'h0080);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    base = done_seen;
    @(posedge clk); #1;
    check("reset_en", bank_en, 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", req_ready, 1'b1);
    check("reset_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("no_done_after_reset", done_seen, base);
    check_single();

`ifdef QSCHED_BROADCAST_EN
    $display("[TB] broadcast write");
    base = done_seen;
    send(4'd6, 6'd0, 16'h0000, 1'b1, 1'b0, ta);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bcast_en", bank_en, 16'hFFFF);
    wait_done(base + 1);
`endif

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qbank_write_scheduler.md
# qbank_write_scheduler

Sequences writes into the 16 per-action Q-value banks. Update requests (state index, action index, data) are queued in a small FIFO and then replayed one at a time. For each request the block holds the address and data stable, drives the one-hot bank write enable selected by the 4-bit action index for a programmable number of cycles, then releases it. It sits between the Q-update datapath and the action-indexed bank array, and replaces ad-hoc wiring of the action decoder outputs to the bank enables.

## Interface
Parameters:
- STATE_W, 6, width of state index / bank address
- DATA_W, 16, width of Q-value written
- FIFO_DEPTH, 4, request queue depth (power of two, 2..16)
- WR_CYCLES, 1, cycles bank_en is held per write (1..15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request queue can accept
- req_action  in  4  action index (selects bank)
- req_state  in  STATE_W  bank address
- req_data  in  DATA_W  value to write
- bank_en  out  16  one-hot bank write enable, bit = action index
- bank_addr  out  STATE_W  address to banks
- bank_wdata  out  DATA_W  write data to banks
- busy  out  1  FIFO non-empty or FSM not IDLE
- done  out  1  one-cycle pulse per completed write

## Operation
- Accept on rising clk when req_valid && req_ready. req_ready = !fifo_full, registered from the occupancy count.
- No push when the FIFO is full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle are allowed when the FIFO is not full; occupancy is unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the working registers and go to SETUP.
  - SETUP (1 cycle): bank_addr and bank_wdata are driven from the working registers; bank_en = 0. Go to WRITE and load the counter with WR_CYCLES-1.
  - WRITE: bank_en = 16'b1 << action. Decrement the counter each cycle; at 0, go to HOLD.
  - HOLD (1 cycle): bank_en = 0; addr/data still stable; done = 1. If the FIFO is non-empty, pop and go to SETUP; otherwise go to IDLE.
- bank_addr and bank_wdata keep their last values in IDLE and change only on a pop.
- bank_en is one-hot or zero at all times. Exception: broadcast, see Configuration.
- FIFO order is strict: writes complete in acceptance order.
- FIFO pointers wrap modulo FIFO_DEPTH. The occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values: bank_en=0, bank_addr=0, bank_wdata=0, done=0, busy=0, req_ready=1 (after the reset edge). FSM=IDLE, FIFO empty.
- Latency, with the FSM in IDLE and the FIFO empty:
  - Request accepted at edge N.
  - Popped at edge N+1.
  - bank_en high from edge N+2 for WR_CYCLES cycles.
  - done high for the single cycle starting at edge N+2+WR_CYCLES.
- Back-to-back throughput: one write per WR_CYCLES+2 cycles. HOLD goes directly to SETUP.
- rst asserted mid-write: at the reset edge, bank_en drops to 0, the FIFO is emptied, and pending requests are lost. No done pulse is produced for the aborted write.
- busy drops in the cycle the FSM enters IDLE with the FIFO empty.

## Configuration
- QSCHED_BROADCAST_EN defined:
  - Adds input port req_bcast (1 bit), queued alongside each request.
  - A broadcast entry drives bank_en = 16'hFFFF during WRITE, writing req_data at req_state in all banks (used for table initialisation).
  - Timing is otherwise identical.
- Undefined: the port is absent, and bank_en is strictly one-hot or zero.

## Test plan
- Reset then a single request (action=5, state=3, data=16'h00A5, WR_CYCLES=1):
  - bank_en=16'h0020 for exactly 1 cycle at edge N+2, with bank_addr=3 and bank_wdata=16'h00A5.
  - done pulses at edge N+3.
- Sweep all actions 0..15 back-to-back: bank_en = 1<<a in order; spacing WR_CYCLES+2 cycles; 16 done pulses; busy falls after the last.
- Fill FIFO (4 requests, FSM stalled in WRITE with WR_CYCLES=15): req_ready=0 after the 4th accept; a 5th req_valid is held off until the first pop; no request is lost or reordered.
- Simultaneous push and pop at occupancy 2: occupancy stays at 2; the popped entry is the oldest.
- Assert rst during WRITE: bank_en=0 at the next edge; busy=0; req_ready=1; no done; the next request behaves as after a fresh reset.
- With QSCHED_BROADCAST_EN, a request with req_bcast=1, state=0, data=0: bank_en=16'hFFFF for WR_CYCLES cycles.
